// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Adds overflow detection and a leading-zero blanking mask.
module bcd_seq_converter #(
  parameter int W      = 18,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t state_n;

  logic [W-1:0]      bin_r;
  logic [W-1:0]      bin_n;
  logic [BW-1:0]     dig_r;
  logic [BW-1:0]     dig_n;
  logic [BW-1:0]     dig_adj;
  logic              ovf_r;
  logic              ovf_n;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_n;
  logic              done_n;
  logic              last;
  logic              zero_run;
  logic [DIGITS-1:0] blank_n;

  assign busy = (state == SHIFT);
  assign last = (cnt_r == CW'(W - 1));

  // Per-digit +3 correction; digits never carry into each other.
  always_comb begin
    dig_adj = dig_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_r[4*i +: 4] > 4'd4) begin
        dig_adj[4*i +: 4] = dig_r[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin_r;
    dig_n   = dig_r;
    ovf_n   = ovf_r;
    cnt_n   = cnt_r;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          bin_n   = bin;
          dig_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        {dig_n, bin_n} = {dig_adj, bin_r} << 1;
        ovf_n = ovf_r | dig_adj[BW-1];
        cnt_n = cnt_r + CW'(1);
        if (last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Leading-zero mask from the final digits; digit 0 is never blanked.
  always_comb begin
    blank_n  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (dig_n[4*i +: 4] == 4'd0);
      blank_n[i] = zero_run & ~ovf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_r    <= '0;
      dig_r    <= '0;
      ovf_r    <= 1'b0;
      cnt_r    <= '0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      blank    <= BLANK_RST;
    end else begin
      bin_r <= bin_n;
      dig_r <= dig_n;
      ovf_r <= ovf_n;
      cnt_r <= cnt_n;
      done  <= done_n;
      if (done_n) begin
        bcd      <= dig_n;
        overflow <= ovf_n;
        blank    <= blank_n;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: two configurations,
// decimal reference model, latency and handshake checks.
module tb_bcd_seq_converter;

  localparam int WA = 18;
  localparam int DA = 6;
  localparam int WB = 10;
  localparam int DB = 3;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    logic [5:0]  blank;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          start_a = 1'b0;
  logic [WA-1:0] bin_a = '0;
  logic          busy_a;
  logic          done_a;
  logic [23:0]   bcd_a;
  logic          ovf_a;
  logic [5:0]    blank_a;

  logic          start_b = 1'b0;
  logic [WB-1:0] bin_b = '0;
  logic          busy_b;
  logic          done_b;
  logic [11:0]   bcd_b;
  logic          ovf_b;
  logic [2:0]    blank_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  bcd_seq_converter #(.W(WA), .DIGITS(DA)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a),
    .overflow(ovf_a), .blank(blank_a)
  );

  bcd_seq_converter #(.W(WB), .DIGITS(DB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b),
    .overflow(ovf_b), .blank(blank_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal digits by repeated division; leftover quotient means overflow.
  function automatic exp_t model(input int unsigned v, input int d);
    exp_t e;
    int unsigned x;
    bit z;
    e.bcd = '0;
    e.blank = '0;
    e.cyc = 0;
    x = v;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.ovf = (x != 0);
    z = 1'b1;
    for (int i = d - 1; i >= 1; i--) begin
      z = z && (e.bcd[4*i +: 4] == 4'd0);
      e.blank[i] = z && !e.ovf;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a_bcd", 32'(bcd_a), 32'(ea.bcd));
        check("a_ovf", 32'(ovf_a), 32'(ea.ovf));
        check("a_blank", 32'(blank_a), 32'(ea.blank));
        check("a_latency", cyc, ea.cyc);
      end
    end
    if (done_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b_bcd", 32'(bcd_b), 32'(eb.bcd));
        check("b_ovf", 32'(ovf_b), 32'(eb.ovf));
        check("b_blank", 32'(blank_b), 32'(eb.blank));
        check("b_latency", cyc, eb.cyc);
      end
    end
  end

  task automatic push(input bit sel, input int unsigned v);
    exp_t e;
    if (!sel) begin
      e = model(v, DA);
      e.cyc = cyc + 1 + WA;
      qa.push_back(e);
    end else begin
      e = model(v, DB);
      e.cyc = cyc + 1 + WB;
      qb.push_back(e);
    end
  endtask

  task automatic issue(input bit sel, input int unsigned v);
    @(negedge clk);
    if (!sel) begin
      bin_a = WA'(v);
      start_a = 1'b1;
    end else begin
      bin_b = WB'(v);
      start_b = 1'b1;
    end
    push(sel, v);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!sel && !busy_a && qa.size() == 0) return;
      if (sel && !busy_b && qb.size() == 0) return;
    end
    check(sel ? "b_idle_timeout" : "a_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    int unsigned v;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_blank", 32'(blank_a), 32'b111110);
    check("rst_blank_b", 32'(blank_b), 32'b110);
    reset = 1'b0;

    issue(1'b0, 262143);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_a) break;
      if (busy_a) n++;
      @(negedge clk);
    end
    check("a_busy_cycles", n, WA);
    wait_idle(1'b0);

    issue(1'b0, 0);
    wait_idle(1'b0);
    issue(1'b0, 907);
    wait_idle(1'b0);

    issue(1'b1, 1023);
    wait_idle(1'b1);
    issue(1'b1, 999);
    wait_idle(1'b1);

    issue(1'b0, 12345);
    repeat (4) @(negedge clk);
    bin_a = WA'(54321);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle(1'b0);

    @(negedge clk);
    bin_a = WA'(1111);
    start_a = 1'b1;
    push(1'b0, 1111);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_a) begin
        n = 1;
        break;
      end
    end
    check("a_held_first_done", n, 1);
    bin_a = WA'(2222);
    push(1'b0, 2222);
    @(negedge clk);
    start_a = 1'b0;
    wait_idle(1'b0);

    issue(1'b0, 5000);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    qa.delete();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_bcd", 32'(bcd_a), 32'd0);
    check("mid_rst_ovf", 32'(ovf_a), 32'd0);
    check("mid_rst_blank", 32'(blank_a), 32'b111110);
    reset = 1'b0;
    repeat (WA + 5) @(negedge clk);
    issue(1'b0, 123456);
    wait_idle(1'b0);

    for (int i = 0; i < 1000; i++) begin
      v = $urandom_range(0, (1 << WA) - 1);
      issue(1'b0, v);
      wait_idle(1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      v = $urandom_range(0, (1 << WB) - 1);
      issue(1'b1, v);
      wait_idle(1'b1);
    end

    repeat (5) @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential, parametrised binary-to-BCD converter using iterative double-dabble: one bit per clock, with a start/busy/done handshake.
- Replaces the fully unrolled combinational converter on wide score/counter paths, trading latency for area and timing.
- Adds configurable digit count, overflow detection, and a leading-zero blanking mask consumed by the seven-segment/HUD score renderer.

Parameters:
- W, 18, binary input width (W >= 4).
- DIGITS, 6, number of BCD output digits (DIGITS >= 1); may be fewer than needed to represent 2^W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion of bin; sampled only when idle
- bin  input  W  binary value, captured on accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: bcd/overflow/blank updated
- bcd  output  4*DIGITS  result {digit DIGITS-1, ..., digit 0}, digit 0 = ones
- overflow  output  1  value exceeded 10^DIGITS-1 in last conversion
- blank  output  DIGITS  blank[i]=1 when digit i is a leading zero

Behaviour:
- Reset (sync, active-high; overrides everything, including mid-conversion):
  - busy=0, done=0, bcd=0, overflow=0, blank = all ones except blank[0]=0.
  - FSM to IDLE; shift counter and working registers cleared.
- FSM states: IDLE, SHIFT.
  - IDLE: start=1 at edge k loads working register: binary part <- bin, BCD part <- 0, ovf_acc <- 0, count <- 0. Go to SHIFT; busy=1 from cycle after edge k.
  - SHIFT, each edge:
    - Every digit with value > 4 gets +3 (4-bit, no carry between digits).
    - Then the {BCD, binary} register shifts left 1.
    - The bit shifted out of the top of digit DIGITS-1 is ORed into ovf_acc.
    - count increments.
  - SHIFT on the W-th shift edge (edge k+W):
    - Shift completes; state -> IDLE; busy=0.
    - bcd, overflow (=ovf_acc including that edge's shifted-out bit) and blank are registered; done=1 for exactly one cycle.
  - Total latency: start sampled at edge k -> done high and results valid in the cycle after edge k+W (W cycles). W=18 -> 18 cycles.
- Outputs bcd/overflow/blank hold their last values until the next done; they never show intermediate values.
- start while busy=1: ignored; no queueing, no effect on the running conversion.
- start during the done-high cycle: accepted, since FSM is already IDLE. Back-to-back throughput is one conversion per W+1 cycles.
- bin may change freely after the accepting edge.
- Overflow:
  - When the value exceeds 10^DIGITS-1, bcd holds value mod 10^DIGITS (low digits remain exact) and overflow=1.
  - Otherwise overflow=0.
- Blank mask, computed from the final bcd:
  - blank[i]=1 iff digit i and all higher digits are zero, for i >= 1.
  - blank[0] is always 0, so value 0 shows a single "0".
  - On overflow, blank is all zeros.
- Arithmetic: the working register is 4*DIGITS+W bits. The per-digit compare/add is combinational within one cycle; there is no multi-cycle path.

Test Plan:
- W=18, DIGITS=6, bin=262143, start pulse at edge k -> done in cycle after edge k+18; bcd=0x262143, overflow=0, blank=6'b000000; busy high exactly 18 cycles.
- bin=0 -> bcd=0x000000, blank=6'b111110, overflow=0. bin=907 -> bcd=0x000907, blank=6'b111000.
- W=10, DIGITS=3, bin=1023 -> bcd=0x023, overflow=1, blank=3'b000. Then bin=999 -> bcd=0x999, overflow=0.
- Start bin=12345, re-pulse start with bin=54321 at cycle 5 of busy -> one done only, bcd=0x012345. Start held high through done -> second conversion begins immediately; its done appears exactly W+1 cycles after the first done.
- Reset asserted mid-conversion (cycle 9) -> next cycle busy=0, done=0, bcd=0, blank=6'b111110; no done pulse follows. A fresh start converts correctly.
- Random sweep, 1000 values, W=18, DIGITS=6 -> every bcd matches the decimal digits of bin; overflow never set.
